sliding_window_average: RTL
===========================

# sliding_window_average

Parametrised streaming moving-average unit: accepts one DATA_W-bit sample per valid cycle and, once 2^LOG2_DEPTH samples have been collected, outputs the mean of the most recent window on every accepted sample. It replaces the fixed-width standing average wherever the averaging stages need a configurable sample width, window depth and rounding mode. It also adds a valid handshake and a synchronous clear.

## Interface
- DATA_W, 8: sample width in bits (unsigned), 2..32.
- LOG2_DEPTH, 3: window depth = 2^LOG2_DEPTH samples, 1..8.
- ROUND, 0: 0 = truncate the mean; 1 = round half up.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous and active-low.
- data_in  input  DATA_W  sample, unsigned.
- in_valid  input  1  sample present this cycle.
- clear  input  1  synchronous window flush, active-high.
- mean  output  DATA_W  registered window mean.
- mean_valid  output  1  one-cycle strobe: a new mean is on `mean`.
- sum  output  DATA_W+LOG2_DEPTH  registered running window sum (SUM_W).
- primed  output  1  window full; steady-state averaging active.

## Operation
- FSM with two states:
  - FILL (reset state): accept samples, keep mean_valid low.
  - RUN: the window is full.
- A sample is accepted on any edge with in_valid=1, rst=1 and clear=0. No backpressure exists, so every valid sample is consumed.
- Circular buffer of DEPTH entries, write pointer wr_ptr of LOG2_DEPTH bits:
  - An accepted sample is written at wr_ptr.
  - wr_ptr then increments modulo DEPTH, wrapping from DEPTH-1 to 0.
- Running sum:
  - FILL: sum ← sum + data_in.
  - RUN: sum ← sum + data_in − buf[wr_ptr]. The read of buf[wr_ptr] returns the oldest sample, taken before it is overwritten.
  - SUM_W bits never overflow.
- Fill count: saturating count 0..DEPTH. On the accept that makes count = DEPTH, the state moves FILL→RUN and primed is set.
- Buffer contents are not reset. In FILL the oldest value is never subtracted, so stale RAM never affects the result.
- Mean:
  - ROUND=0: mean = new_sum >> LOG2_DEPTH.
  - ROUND=1: mean = (new_sum + 2^(LOG2_DEPTH−1)) >> LOG2_DEPTH, computed at SUM_W+1 bits and then saturated to 2^DATA_W−1.
- mean_valid is high for one cycle after each accept whose resulting state is RUN. This includes the accept that fills the window.
- Between accepts, mean and sum hold their values and mean_valid=0.
- clear or rst=0 (either one):
  - state→FILL, count=0, wr_ptr=0, sum=0, mean=0, mean_valid=0, primed=0.
  - A sample presented in the same cycle is dropped.
  - Priority: rst > clear > in_valid.

## Timing
- Reset values: mean=0, mean_valid=0, sum=0, primed=0.
- Latency: a sample accepted at edge k is reflected in sum, mean and mean_valid after edge k.
- primed rises on the same edge as the first mean_valid.
- Back-to-back accepts on every cycle are supported at full rate. The buffer uses a read-before-write RAM port with a combinational read, so there is no extra pipeline stage.
- clear or rst mid-window discards all history. The next DEPTH accepted samples refill the window before mean_valid returns.

## Structure
- Shared package avg_pkg holds:
  - FSM state encodings ST_FILL and ST_RUN.
  - SUM_W derivation (DATA_W+LOG2_DEPTH).
  - Rounding mode constants RND_TRUNC and RND_HALF_UP.
- Sub-module avg_window_buf: DEPTH×DATA_W circular RAM with one write port and a combinational read at the same address.
- The top level holds the FSM, pointer, counter, sum and mean datapath.

## Test plan
All scenarios use DATA_W=8 and LOG2_DEPTH=3 unless stated otherwise.
- Reset: hold rst=0 for 3 cycles with in_valid=1 and data_in=0xFF → mean=0, sum=0, mean_valid=0, primed=0 throughout.
- Fill: 8 accepts of 10 → no mean_valid on the first 7. After the 8th: sum=80, mean=10, mean_valid=1, primed=1.
- Sliding, ROUND=0: after the fill, accepts of 20 → means 11, 12, 13, 15, 16, 17, 18, 20 with sums 90..160.
- Sliding, ROUND=1: same as the sliding scenario; the second mean (sum 100) = 13.
- Extremes and gaps:
  - 8 samples of 255 → sum=2040 and mean=255 for both ROUND settings.
  - Idle cycles between accepts → outputs hold and mean_valid=0.
- Clear mid-run: assert clear together with in_valid (data 99) in RUN → all outputs 0 next cycle and the sample is dropped. Then 8 samples of 4 → first mean_valid with mean=4. Repeat the scenario using rst=0 in place of clear.

Source files
------------

// File: rtl/avg_pkg.sv
// Shared definitions for the sliding-window averager: FSM states, sum width
// derivation and rounding-mode selectors.
package avg_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned RND_TRUNC   = 0;
  localparam int unsigned RND_HALF_UP = 1;

  // A window of 2^log2_depth samples of data_w bits never exceeds this width.
  function automatic int unsigned sum_width(input int unsigned data_w,
                                            input int unsigned log2_depth);
    return data_w + log2_depth;
  endfunction

endpackage

// File: rtl/sliding_window_average_if.sv
// Stream bundle for the sliding-window averager.
//   master: drives data_in / in_valid / clear, observes mean, mean_valid, sum, primed
//   slave : the averager itself
interface sliding_window_average_if
  import avg_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LOG2_DEPTH = 3
);
  localparam int unsigned SUM_W = sum_width(DATA_W, LOG2_DEPTH);

  logic [DATA_W-1:0] data_in;
  logic              in_valid;
  logic              clear;
  logic [DATA_W-1:0] mean;
  logic              mean_valid;
  logic [SUM_W-1:0]  sum;
  logic              primed;

  modport master (
    output data_in, in_valid, clear,
    input  mean, mean_valid, sum, primed
  );

  modport slave (
    input  data_in, in_valid, clear,
    output mean, mean_valid, sum, primed
  );

endinterface

// File: rtl/avg_window_buf.sv
// Circular sample store: one write port and a combinational read at the same
// address, so the oldest sample is visible before it is overwritten.
//   clk   : clock
//   we    : write enable
//   addr  : shared read/write address
//   wdata : sample to store
//   rdata : current contents at addr (pre-write value)
module avg_window_buf #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LOG2_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LOG2_DEPTH-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);
  localparam int unsigned DEPTH = 32'(1) << LOG2_DEPTH;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents deliberately not reset; stale entries are never read while filling.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sliding_window_average.sv
// Streaming moving average over the last 2^LOG2_DEPTH samples.
//   clk  : clock
//   rst  : synchronous active-low reset
//   bus  : slave side of sliding_window_average_if
//          (data_in, in_valid, clear in; mean, mean_valid, sum, primed out)
module sliding_window_average
  import avg_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LOG2_DEPTH = 3,
  parameter int unsigned ROUND      = RND_TRUNC
) (
  input  logic                     clk,
  input  logic                     rst,
  sliding_window_average_if.slave  bus
);
  localparam int unsigned DEPTH  = 32'(1) << LOG2_DEPTH;
  localparam int unsigned HALF   = DEPTH >> 1;
  localparam int unsigned SUM_W  = sum_width(DATA_W, LOG2_DEPTH);
  localparam int unsigned CNT_W  = LOG2_DEPTH + 1;
  localparam int unsigned MEAN_W = DATA_W + 1;

  state_t                state_q, state_d;
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [DATA_W-1:0]     mean_q, mean_d;
  logic                  mean_valid_q, mean_valid_d;
  logic                  primed_q, primed_d;

  logic                  accept_c;
  logic [DATA_W-1:0]     oldest_c;
  logic [SUM_W-1:0]      new_sum_c;
  logic [SUM_W:0]        rounded_c;
  logic [MEAN_W-1:0]     mean_wide_c;
  logic [DATA_W-1:0]     mean_sat_c;

  assign accept_c = rst && bus.in_valid && !bus.clear;

  avg_window_buf #(
    .DATA_W     (DATA_W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_buf (
    .clk   (clk),
    .we    (accept_c),
    .addr  (wr_ptr_q),
    .wdata (bus.data_in),
    .rdata (oldest_c)
  );

  // Mean datapath: oldest sample only leaves the sum once the window is full.
  always_comb begin
    new_sum_c = sum_q + SUM_W'(bus.data_in)
              - ((state_q == ST_RUN) ? SUM_W'(oldest_c) : SUM_W'(0));
    rounded_c = (SUM_W+1)'(new_sum_c) + (SUM_W+1)'(HALF);
    if (ROUND == RND_HALF_UP) mean_wide_c = MEAN_W'(rounded_c >> LOG2_DEPTH);
    else                      mean_wide_c = MEAN_W'(new_sum_c >> LOG2_DEPTH);
    mean_sat_c = mean_wide_c[MEAN_W-1] ? {DATA_W{1'b1}} : mean_wide_c[DATA_W-1:0];
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    sum_d        = sum_q;
    mean_d       = mean_q;
    mean_valid_d = 1'b0;
    primed_d     = primed_q;

    if (bus.clear) begin
      state_d  = ST_FILL;
      wr_ptr_d = '0;
      count_d  = '0;
      sum_d    = '0;
      mean_d   = '0;
      primed_d = 1'b0;
    end else if (accept_c) begin
      wr_ptr_d = wr_ptr_q + LOG2_DEPTH'(1);
      sum_d    = new_sum_c;
      mean_d   = mean_sat_c;
      case (state_q)
        ST_FILL: begin
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(DEPTH - 1)) begin
            state_d      = ST_RUN;
            primed_d     = 1'b1;
            mean_valid_d = 1'b1;
          end
        end
        ST_RUN: mean_valid_d = 1'b1;
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_FILL;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      sum_q        <= '0;
      mean_q       <= '0;
      mean_valid_q <= 1'b0;
      primed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      sum_q        <= sum_d;
      mean_q       <= mean_d;
      mean_valid_q <= mean_valid_d;
      primed_q     <= primed_d;
    end
  end

  assign bus.mean       = mean_q;
  assign bus.mean_valid = mean_valid_q;
  assign bus.sum        = sum_q;
  assign bus.primed     = primed_q;

endmodule
